// File: rtl/if_fetch_unit.sv
// if_fetch_unit - instruction fetch stage.
//
// Owns the program counter and reads 16-bit instructions from instruction
// memory over a req/ready handshake. It presents pc, pc+2 and the fetched
// word to the IF/ID register, and inserts a bubble (16'h0000) whenever no
// valid instruction is available.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | request outstanding at pc; forward data on ready
// HOLD   | word arrived during freeze; replay held_ir until released
// DRAIN  | redirect seen mid-request; finish old request, then jump
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   freeze      in   pipeline stall (same as IF/ID freeze)
//   br_taken    in   redirect request from execute
//   br_target   in   [15:0] redirect address (bit 0 forced to 0)
//   imem_req    out  read request to instruction memory
//   imem_addr   out  [15:0] byte address of the request
//   imem_ready  in   memory completes the request this cycle
//   imem_rdata  in   [15:0] instruction word, valid with req & ready
//   pc_out      out  [15:0] address of the word on ir_out
//   pc2_out     out  [15:0] pc_out + 2 (mod 2^16)
//   ir_out      out  [15:0] instruction to IF/ID, 0 = bubble
//   fetch_busy  out  bubble caused by waiting on memory

module if_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] pc_out,
   output logic [15:0] pc2_out,
   output logic [15:0] ir_out,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] tgt_q, tgt_d;
   logic [15:0] held_ir_q, held_ir_d;

   logic        redirect;
   logic [15:0] br_tgt_even;
   logic [15:0] pc_inc;

   // Freeze wins over redirect, matching IF/ID; execute re-presents later.
   assign redirect    = br_taken & ~freeze;
   assign br_tgt_even = br_target & 16'hFFFE;
   assign pc_inc      = pc_q + 16'd2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         tgt_q     <= 16'h0000;
         held_ir_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tgt_q     <= tgt_d;
         held_ir_q <= held_ir_d;
      end
   end

   logic        req_c;
   logic [15:0] ir_c;
   logic        busy_c;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      held_ir_d = held_ir_q;
      req_c     = 1'b0;
      ir_c      = 16'h0000;
      busy_c    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            req_c  = 1'b1;
            busy_c = ~imem_ready;
            if (redirect) begin
               if (imem_ready) begin
                  pc_d = br_tgt_even;
               end else begin
                  // Memory still owes us the old word; address must stay put.
                  tgt_d   = br_tgt_even;
                  state_d = S_DRAIN;
               end
            end else if (imem_ready) begin
               ir_c = imem_rdata;
               if (freeze) begin
                  held_ir_d = imem_rdata;
                  state_d   = S_HOLD;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end

         S_HOLD: begin
            ir_c = held_ir_q;
            if (redirect) begin
               ir_c    = 16'h0000;
               pc_d    = br_tgt_even;
               state_d = S_FETCH;
            end else if (!freeze) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end

         S_DRAIN: begin
            req_c  = 1'b1;
            busy_c = 1'b1;
            if (redirect) begin
               tgt_d = br_tgt_even;
            end
            if (imem_ready) begin
               pc_d    = redirect ? br_tgt_even : tgt_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset abandons any request and shows a bubble.
   assign imem_req   = req_c & ~rst;
   assign ir_out     = rst ? 16'h0000 : ir_c;
   assign fetch_busy = busy_c & ~rst;
   assign imem_addr  = pc_q;
   assign pc_out     = pc_q;
   assign pc2_out    = pc_inc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table followed by a long
// random run checked against a flag-based behavioural model.

module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, br_taken, imem_ready;
   logic [15:0] br_target;
   logic        imem_req, fetch_busy;
   logic [15:0] imem_addr, imem_rdata, pc_out, pc2_out, ir_out;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Memory returns a word derived from the address it was asked for.
   assign imem_rdata = imem_addr ^ 16'hA5A5;

   if_fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .pc_out     (pc_out),
      .pc2_out    (pc2_out),
      .ir_out     (ir_out),
      .fetch_busy (fetch_busy)
   );

   typedef struct {
      logic        rst;
      logic        fz;
      logic        br;
      logic [15:0] tgt;
      logic        rdy;
      logic [15:0] pc;
      logic        req;
      logic [15:0] ir;
      logic        busy;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic r, logic f, logic b, logic [15:0] t, logic rd,
                               logic [15:0] p, logic q, logic [15:0] i, logic bz);
      vec_t v;
      v.rst = r; v.fz = f; v.br = b; v.tgt = t; v.rdy = rd;
      v.pc = p; v.req = q; v.ir = i; v.busy = bz;
      return v;
   endfunction

   task automatic check(string tag, int idx, logic [15:0] e_pc, logic e_req,
                        logic [15:0] e_ir, logic e_busy);
      vectors++;
      if (pc_out !== e_pc) begin
         miscompares++;
         $display("FAIL %s[%0d] pc_out got %h want %h", tag, idx, pc_out, e_pc);
      end
      if (pc2_out !== e_pc + 16'd2) begin
         miscompares++;
         $display("FAIL %s[%0d] pc2_out got %h want %h", tag, idx, pc2_out, e_pc + 16'd2);
      end
      if (imem_addr !== e_pc) begin
         miscompares++;
         $display("FAIL %s[%0d] imem_addr got %h want %h", tag, idx, imem_addr, e_pc);
      end
      if (imem_req !== e_req) begin
         miscompares++;
         $display("FAIL %s[%0d] imem_req got %b want %b", tag, idx, imem_req, e_req);
      end
      if (ir_out !== e_ir) begin
         miscompares++;
         $display("FAIL %s[%0d] ir_out got %h want %h", tag, idx, ir_out, e_ir);
      end
      if (fetch_busy !== e_busy) begin
         miscompares++;
         $display("FAIL %s[%0d] fetch_busy got %b want %b", tag, idx, fetch_busy, e_busy);
      end
   endtask

   // Reference model: pc, a "holding a word" flag and a "redirect owed" flag.
   logic [15:0] m_pc, m_tgt, m_held;
   bit          m_hold, m_drain;

   task automatic model_cycle(int idx, logic r, logic f, logic b, logic [15:0] t, logic rd);
      logic [15:0] e_ir;
      logic        e_req, e_busy;
      logic        redir;
      logic [15:0] t_even;
      redir  = b && !f;
      t_even = {t[15:1], 1'b0};
      e_ir   = 16'h0000;
      e_req  = 1'b0;
      e_busy = 1'b0;
      if (r) begin
         check("rand", idx, m_pc, 1'b0, 16'h0000, 1'b0);
         m_pc = 16'h0000; m_tgt = 16'h0000; m_held = 16'h0000;
         m_hold = 0; m_drain = 0;
         return;
      end
      if (m_hold) begin
         e_ir = redir ? 16'h0000 : m_held;
         check("rand", idx, m_pc, 1'b0, e_ir, 1'b0);
         if (redir) begin m_pc = t_even; m_hold = 0; end
         else if (!f) begin m_pc = m_pc + 16'd2; m_hold = 0; end
      end else if (m_drain) begin
         check("rand", idx, m_pc, 1'b1, 16'h0000, 1'b1);
         if (redir) m_tgt = t_even;
         if (rd) begin m_pc = m_tgt; m_drain = 0; end
      end else begin
         e_req  = 1'b1;
         e_busy = !rd;
         if (!redir && rd) e_ir = m_pc ^ 16'hA5A5;
         check("rand", idx, m_pc, e_req, e_ir, e_busy);
         if (redir) begin
            if (rd) m_pc = t_even;
            else begin m_tgt = t_even; m_drain = 1; end
         end else if (rd) begin
            if (f) begin m_held = m_pc ^ 16'hA5A5; m_hold = 1; end
            else m_pc = m_pc + 16'd2;
         end
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_target = 16'h0000; imem_ready = 1'b1;

      //         rst fz br tgt      rdy  pc       req ir       busy
      vt.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hA5A5, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'hA5A7, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0004, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0004, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'hA5A1, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'hA5A3, 0));
      vt.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0008, 1, 16'hA5AD, 0));
      vt.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'hA5AD, 0));
      vt.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'hA5AD, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'hA5AD, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000A, 1, 16'hA5AF, 0));
      vt.push_back(mk(0, 0, 1, 16'h0040, 0, 16'h000C, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h000C, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000C, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0040, 1, 16'hA5E5, 0));
      vt.push_back(mk(0, 1, 1, 16'h0100, 0, 16'h0042, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 1, 16'h0031, 1, 16'h0042, 1, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0030, 1, 16'hA595, 0));
      vt.push_back(mk(0, 0, 1, 16'hFFFF, 1, 16'h0032, 1, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 16'h5A5B, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hA5A5, 0));
      vt.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'hA5A7, 0));
      vt.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hA5A5, 0));
      vt.push_back(mk(0, 0, 1, 16'h0080, 0, 16'h0002, 1, 16'h0000, 1));
      vt.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0002, 0, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hA5A5, 0));
      vt.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'hA5A7, 0));
      vt.push_back(mk(0, 0, 1, 16'h0200, 1, 16'h0002, 0, 16'h0000, 0));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0200, 1, 16'hA7A5, 0));
      vt.push_back(mk(0, 0, 1, 16'h0300, 0, 16'h0202, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 1, 16'h0400, 1, 16'h0202, 1, 16'h0000, 1));
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0400, 1, 16'hA1A5, 0));

      // Initial reset so the first table row sees defined state.
      repeat (2) @(posedge clk);

      foreach (vt[i]) begin
         @(negedge clk);
         rst = vt[i].rst; freeze = vt[i].fz; br_taken = vt[i].br;
         br_target = vt[i].tgt; imem_ready = vt[i].rdy;
         #1;
         check("vec", i, vt[i].pc, vt[i].req, vt[i].ir, vt[i].busy);
      end

      // Random run against the model, starting from a fresh reset.
      @(negedge clk);
      rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      m_pc = 16'h0000; m_tgt = 16'h0000; m_held = 16'h0000; m_hold = 0; m_drain = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n > 0) @(negedge clk);
         rst        = ($urandom_range(63) == 0);
         freeze     = ($urandom_range(3) == 0);
         br_taken   = ($urandom_range(5) == 0);
         br_target  = 16'($urandom);
         imem_ready = ($urandom_range(2) != 0);
         #1;
         model_cycle(n, rst, freeze, br_taken, br_target, imem_ready);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage. Owns the program counter and issues 16-bit instruction reads to instruction memory over a req/ready handshake.
- Presents pc, pc+2 and the fetched instruction word to the IF/ID pipeline register.
- Honours the pipeline-wide freeze (stall) and the branch redirect from execute.
- Inserts NOPs (IR = 16'h0000) whenever no valid instruction is available, so IF/ID sees a bubble.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset. Must be even.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- freeze, input, 1, pipeline stall; same signal that drives IF/ID freeze.
- br_taken, input, 1, branch/jump resolved taken in execute; redirect fetch.
- br_target, input, 16, redirect address; valid when br_taken=1. Bit 0 ignored (forced 0).
- imem_req, output, 1, read request to instruction memory.
- imem_addr, output, 16, byte address of the requested instruction.
- imem_ready, input, 1, memory completes the request this cycle. Only meaningful while imem_req=1.
- imem_rdata, input, 16, instruction word; valid when imem_req & imem_ready.
- pc_out, output, 16, address of the instruction on ir_out; to IF/ID pc_in.
- pc2_out, output, 16, pc_out+2 mod 2^16; to IF/ID pc2_in.
- ir_out, output, 16, instruction to IF/ID IR_in; 16'h0000 = bubble.
- fetch_busy, output, 1, high when ir_out is a bubble because fetch is waiting on memory.

Behaviour:
- Reset: pc = RESET_PC, state = FETCH, held_ir = 0, tgt = 0. While rst=1, force imem_req=0 and ir_out=0. Reset mid-transaction abandons the request; memory is reset by the same rst.
- Registers: pc (16), tgt (16), held_ir (16), state (FETCH, HOLD, DRAIN).
- Outputs: pc_out = pc and pc2_out = pc+2 in every state. imem_addr = pc and stays stable while imem_req=1 until imem_ready. ir_out and pc/pc2 are combinational from state/regs/imem_rdata. IF/ID samples them at the same edge the fetch unit updates.
- br_taken is honoured only when freeze=0, matching IF/ID, where freeze has priority over flush. Execute is frozen too, so it re-presents the branch after the stall.
- Redirect (br_taken & !freeze) takes priority over everything else.
- FETCH: imem_req=1.
  - br_taken & !freeze & imem_ready: drop data, ir_out=0, pc <= br_target, stay FETCH.
  - br_taken & !freeze & !imem_ready: ir_out=0, tgt <= br_target, go DRAIN.
  - imem_ready & !freeze: ir_out = imem_rdata, pc <= pc+2, stay FETCH. Zero-wait memory gives 1 instr/cycle.
  - imem_ready & freeze: ir_out = imem_rdata (IF/ID ignores it), held_ir <= imem_rdata, go HOLD, pc unchanged.
  - !imem_ready: ir_out=0, fetch_busy=1.
- HOLD: imem_req=0, ir_out = held_ir.
  - br_taken & !freeze: ir_out=0, pc <= br_target, go FETCH.
  - !freeze: IF/ID captures held_ir this edge, pc <= pc+2, go FETCH.
  - freeze: stay.
- DRAIN: imem_req=1 on the old pc, ir_out=0, fetch_busy=1.
  - br_taken & !freeze: tgt <= br_target; the latest redirect wins.
  - imem_ready: discard data, pc <= tgt (or br_target if a new redirect arrives the same cycle), go FETCH.
- Arithmetic: all pc math is 16-bit modulo. 16'hFFFE + 2 wraps to 16'h0000; no overflow flag.
- Latency: with zero-wait memory, an instruction appears on ir_out the cycle after pc is loaded. A branch redirect costs 1 bubble from the fetch side, plus 1 IF/ID flush. Each memory wait state adds 1 bubble.

Test Plan:
- Reset then zero-wait memory (ready=1, rdata=addr^16'hA5A5), no freeze/branch for 4 cycles -> pc_out 0,2,4,6; ir_out A5A5,A5A7,A5A1,A5A3; pc2_out = pc_out+2.
- Memory ready low for 2 cycles at pc=4 -> ir_out=0 and fetch_busy=1 for 2 cycles, imem_addr held at 4; then ir_out=rdata(4) and pc advances to 6.
- freeze=1 for 3 cycles coinciding with ready at pc=8 -> state HOLD, imem_req=0, ir_out=held rdata(8) throughout, pc stays 8; on freeze=0, pc becomes 10 next cycle and the fetch of 10 is issued.
- br_taken=1, br_target=16'h0040 while request to 12 has ready=0, held 2 cycles -> DRAIN, addr stays 12, ir_out=0; after ready, imem_addr=16'h0040. br_taken with freeze=1 -> ignored, pc unchanged.
- pc=16'hFFFE with zero-wait memory -> pc2_out=16'h0000, next pc_out=16'h0000. br_target=16'h0031 -> fetch address 16'h0030.
- rst asserted in DRAIN and in HOLD -> next cycle pc=RESET_PC, imem_req=0 during rst, ir_out=0; fetch resumes at RESET_PC the cycle after rst drops.
